// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB) driving datapath
//            write enables and mux selects, with a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   zero,
  output logic [2:0]             state,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   DRWrite,
  output logic                   ALUResWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic [1:0]             PCSrc,
  output logic                   ALUSrcB,
  output logic [1:0]             ExtOp,
  output logic [2:0]             ALUOp,
  output logic                   RegDst,
  output logic                   MemToReg,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_retire;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_addu, w_subu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_undef;

  assign w_addu  = (opcode == c_OP_RTYPE) && (funct == c_FN_ADDU);
  assign w_subu  = (opcode == c_OP_RTYPE) && (funct == c_FN_SUBU);
  assign w_ori   = (opcode == c_OP_ORI);
  assign w_lui   = (opcode == c_OP_LUI);
  assign w_lw    = (opcode == c_OP_LW);
  assign w_sw    = (opcode == c_OP_SW);
  assign w_beq   = (opcode == c_OP_BEQ);
  assign w_j     = (opcode == c_OP_J);
  assign w_undef = !(w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq | w_j);

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = S_ID;
      S_ID:  w_next = (w_j || w_undef) ? S_IF : S_EXE;
      S_EXE: begin
        if (w_beq)              w_next = S_IF;
        else if (w_lw || w_sw)  w_next = S_MEM;
        else if (!w_undef)      w_next = S_WB;
        else                    w_next = S_IF;
      end
      S_MEM: w_next = w_lw ? S_WB : S_IF;
      S_WB:  w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  // An undefined opcode bounced back from ID never retires.
  assign w_retire = (w_next == S_IF) && (r_state != S_IF) &&
                    !((r_state == S_ID) && w_undef);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IF;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign state       = r_state;
  assign instr_count = r_count;

  always_comb begin
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    DRWrite     = 1'b0;
    ALUResWrite = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcB     = 1'b0;
    ExtOp       = 2'b00;
    ALUOp       = 3'b000;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    if (rst) begin
      case (r_state)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_ID: begin
          if (w_j) begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
          end
        end
        S_EXE: begin
          ALUResWrite = 1'b1;
          if (w_subu) begin
            ALUOp = 3'b001;
          end else if (w_ori) begin
            ALUOp   = 3'b010;
            ALUSrcB = 1'b1;
          end else if (w_lui) begin
            ALUSrcB = 1'b1;
            ExtOp   = 2'b10;
          end else if (w_lw || w_sw) begin
            ALUSrcB = 1'b1;
            ExtOp   = 2'b01;
          end else if (w_beq) begin
            ALUOp       = 3'b001;
            ALUResWrite = 1'b0;
            PCSrc       = 2'b01;
            PCWrite     = zero;
          end
        end
        S_MEM: begin
          DRWrite  = w_lw;
          MemWrite = w_sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = w_addu | w_subu;
          MemToReg = w_lw;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
